sram_bitstream_reader: RTL and testbench

// - Downstream of the UART-to-SRAM loader: streams the compressed bitstream back out of SRAM, starting at Start_address (normally 18'd76800).
// - Presents an MSB-aligned 16-bit peek window to the lossless decoder.
// - Decoder consumes 1..16 bits per cycle; the reader prefetches 16-bit words through a pipelined SRAM read port.

---
 rtl/sram_bitstream_reader_if.sv | 40 ++++
 rtl/sram_bitstream_reader.sv | 147 ++++++++++++++
 tb/tb_sram_bitstream_reader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bitstream_reader_if.sv
// Bus bundle for sram_bitstream_reader: control handshake, SRAM read port and
// decoder-facing bit window. The slave modport is the reader; the master
// modport is the environment (loader control, SRAM, decoder).
// Optional: BITSTREAM_READER_STATS_EN adds Bits_consumed.
interface sram_bitstream_reader_if;
  logic        Start;
  logic [17:0] Start_address;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic [15:0] Bits_out;
  logic        Valid;
  logic        Consume;
  logic [4:0]  Consume_count;
  logic        End_of_memory;
  logic        Error;
`ifdef BITSTREAM_READER_STATS_EN
  logic [23:0] Bits_consumed;

  modport slave (
    input  Start, Start_address, SRAM_read_data, Consume, Consume_count,
    output SRAM_address, SRAM_we_n, Bits_out, Valid, End_of_memory, Error,
           Bits_consumed
  );
  modport master (
    output Start, Start_address, SRAM_read_data, Consume, Consume_count,
    input  SRAM_address, SRAM_we_n, Bits_out, Valid, End_of_memory, Error,
           Bits_consumed
  );
`else
  modport slave (
    input  Start, Start_address, SRAM_read_data, Consume, Consume_count,
    output SRAM_address, SRAM_we_n, Bits_out, Valid, End_of_memory, Error
  );
  modport master (
    output Start, Start_address, SRAM_read_data, Consume, Consume_count,
    input  SRAM_address, SRAM_we_n, Bits_out, Valid, End_of_memory, Error
  );
`endif
endinterface

// File: rtl/sram_bitstream_reader.sv
// Streams the compressed bitstream back out of SRAM and presents an
// MSB-aligned 16-bit peek window to the decoder. Words are prefetched through
// a pipelined read port into a BUF_W-bit left-justified bit buffer.
// Optional: BITSTREAM_READER_STATS_EN adds a saturating Bits_consumed counter.
module sram_bitstream_reader #(
  parameter int READ_LATENCY = 2,
  parameter int BUF_W        = 64
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  sram_bitstream_reader_if.slave bus
);
  localparam int          FW        = $clog2(BUF_W + 1);
  localparam logic [17:0] LAST_ADDR = 18'h3FFFF;

  typedef enum logic [1:0] {S_BR_IDLE, S_BR_RUN, S_BR_DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [17:0]             addr_q, addr_d;
  logic [BUF_W-1:0]        buf_q, buf_d;
  logic [FW-1:0]           fill_q, fill_d;
  logic [READ_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [15:0]             bits_q, bits_d;
  logic                    valid_q, valid_d;
  logic                    eom_q, eom_d;
  logic                    err_q, err_d;

  logic [3:0]       inflight;
  logic [15:0]      need;
  logic             issue, arrive, cons_ok, cons_bad;
  logic [4:0]       cons_amt;
  logic [FW-1:0]    fill_ac;
  logic [BUF_W-1:0] shifted, ins;

  // Count reads issued but not yet appended (one bit per pipe stage).
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++)
      inflight = inflight + {3'b000, vld_pipe_q[i]};
  end

  // Issue only while the buffer plus everything in flight leaves room for one
  // more word; this is what bounds fill_ac so the append never overflows.
  assign need     = 16'(fill_q) + {8'h00, inflight, 4'h0} + 16'd16;
  assign issue    = (state_q == S_BR_RUN) && (need <= 16'(BUF_W));
  assign arrive   = vld_pipe_q[READ_LATENCY-1];
  assign cons_ok  = bus.Consume && valid_q && (bus.Consume_count != 5'd0) &&
                    (bus.Consume_count <= 5'd16);
  assign cons_bad = bus.Consume && !cons_ok;
  assign cons_amt = cons_ok ? bus.Consume_count : 5'd0;
  // Shift out consumed bits first, then drop the arriving word just below the
  // remaining valid bits; bits below fill are always zero so OR is safe.
  assign fill_ac  = fill_q - FW'(cons_amt);
  assign shifted  = buf_q << cons_amt;
  assign ins      = arrive ? ({bus.SRAM_read_data, {(BUF_W-16){1'b0}}} >> fill_ac)
                           : '0;

  // Next-state: Start flushes everything and wins over consume/issue.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    buf_d      = buf_q;
    fill_d     = fill_q;
    vld_pipe_d = vld_pipe_q;
    eom_d      = eom_q;
    err_d      = err_q;
    if (bus.Start) begin
      state_d    = S_BR_RUN;
      addr_d     = bus.Start_address;
      buf_d      = '0;
      fill_d     = '0;
      vld_pipe_d = '0;
      eom_d      = 1'b0;
      err_d      = 1'b0;
    end else begin
      vld_pipe_d = (vld_pipe_q << 1) | READ_LATENCY'(issue);
      if (issue) begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_BR_DRAIN;
          eom_d   = 1'b1;
        end else begin
          addr_d  = addr_q + 18'd1;
        end
      end
      buf_d  = shifted | ins;
      fill_d = fill_ac + (arrive ? FW'(16) : FW'(0));
      if (cons_bad) err_d = 1'b1;
    end
    // Window and Valid are registered alongside the buffer so the new window
    // is visible the cycle after a consume or append.
    bits_d  = buf_d[BUF_W-1 -: 16];
    valid_d = (fill_d >= FW'(16));
  end

  // State registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= S_BR_IDLE;
      addr_q     <= '0;
      buf_q      <= '0;
      fill_q     <= '0;
      vld_pipe_q <= '0;
      bits_q     <= '0;
      valid_q    <= 1'b0;
      eom_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      buf_q      <= buf_d;
      fill_q     <= fill_d;
      vld_pipe_q <= vld_pipe_d;
      bits_q     <= bits_d;
      valid_q    <= valid_d;
      eom_q      <= eom_d;
      err_q      <= err_d;
    end
  end

  assign bus.SRAM_address  = addr_q;
  assign bus.SRAM_we_n     = 1'b1;
  assign bus.Bits_out      = bits_q;
  assign bus.Valid         = valid_q;
  assign bus.End_of_memory = eom_q;
  assign bus.Error         = err_q;

`ifdef BITSTREAM_READER_STATS_EN
  logic [23:0] bc_q, bc_d;
  logic [24:0] bc_sum;

  // Saturating count of legally consumed bits since reset/Start.
  always_comb begin
    bc_sum = {1'b0, bc_q} + 25'(cons_amt);
    bc_d   = bc_q;
    if (bus.Start)    bc_d = '0;
    else if (cons_ok) bc_d = bc_sum[24] ? 24'hFFFFFF : bc_sum[23:0];
  end

  // Stats counter register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) bc_q <= '0;
    else         bc_q <= bc_d;
  end

  assign bus.Bits_consumed = bc_q;
`endif
endmodule

// File: tb/tb_sram_bitstream_reader.sv
// Self-checking bench for sram_bitstream_reader. The SRAM model returns
// address[15:0] two cycles after the address; expected windows come from a
// stream-position model pushed to a scoreboard queue as consumes are driven.
module tb_sram_bitstream_reader;
  logic Clock = 1'b0;
  logic Resetn = 1'b0;
  always #10 Clock = ~Clock;

  sram_bitstream_reader_if bus();

  sram_bitstream_reader #(.READ_LATENCY(2), .BUF_W(64)) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .bus   (bus)
  );

  logic [17:0] sram_a1;
  logic [15:0] sram_rd;
  always @(posedge Clock) begin
    sram_a1 <= bus.SRAM_address;
    sram_rd <= sram_a1[15:0];
  end
  assign bus.SRAM_read_data = sram_rd;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] sb_q[$];
  logic [17:0] base;
  int          pos;

  function automatic logic [15:0] exp_win(input logic [17:0] b, input int p);
    logic [17:0] a0, a1x;
    logic [31:0] two;
    a0  = b + 18'(p / 16);
    a1x = a0 + 18'd1;
    two = {a0[15:0], a1x[15:0]} << (p % 16);
    return two[31:16];
  endfunction

  function automatic logic [15:0] sb_pop();
    if (sb_q.size() == 0) return 'x;
    return sb_q.pop_front();
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_start(input logic [17:0] a);
    bus.Start = 1'b1;
    bus.Start_address = a;
    base = a;
    pos = 0;
    sb_q.delete();
    sb_q.push_back(exp_win(a, 0));
    tick();
    bus.Start = 1'b0;
  endtask

  task automatic consume(input logic [4:0] n);
    bus.Consume = 1'b1;
    bus.Consume_count = n;
    pos += int'(n);
    sb_q.push_back(exp_win(base, pos));
    tick();
    bus.Consume = 1'b0;
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    repeat (3) tick();
    vectors++; if (bus.SRAM_address !== 18'd0) begin miscompares++; $display("FAIL reset_addr got %h want 0", bus.SRAM_address); end
    vectors++; if (bus.SRAM_we_n !== 1'b1) begin miscompares++; $display("FAIL reset_we_n got %b want 1", bus.SRAM_we_n); end
    vectors++; if (bus.Bits_out !== 16'h0) begin miscompares++; $display("FAIL reset_bits got %h want 0", bus.Bits_out); end
    vectors++; if (bus.Valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", bus.Valid); end
    vectors++; if (bus.End_of_memory !== 1'b0) begin miscompares++; $display("FAIL reset_eom got %b want 0", bus.End_of_memory); end
    vectors++; if (bus.Error !== 1'b0) begin miscompares++; $display("FAIL reset_error got %b want 0", bus.Error); end
    Resetn = 1'b1;
    tick();
  endtask

  task automatic test_start_latency();
    logic [15:0] e;
    do_start(18'd76800);
    vectors++; if (bus.SRAM_address !== 18'd76800) begin miscompares++; $display("FAIL start_addr0 got %0d want 76800", bus.SRAM_address); end
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) tick();
      if (c == 2) begin
        vectors++; if (bus.SRAM_address !== 18'd76801) begin miscompares++; $display("FAIL start_addr1 got %0d want 76801", bus.SRAM_address); end
      end
      vectors++; if (bus.Valid !== (c == 4)) begin miscompares++; $display("FAIL start_valid_c%0d got %b want %b", c, bus.Valid, c == 4); end
    end
    e = sb_pop();
    vectors++; if (bus.Bits_out !== e) begin miscompares++; $display("FAIL first_window got %h want %h", bus.Bits_out, e); end
  endtask

  task automatic test_partial_consume();
    logic [15:0] e;
    consume(5'd4);
    e = sb_pop();
    vectors++; if (bus.Valid !== 1'b1 || bus.Bits_out !== e) begin miscompares++; $display("FAIL consume4 got %b/%h want 1/%h", bus.Valid, bus.Bits_out, e); end
    consume(5'd12);
    e = sb_pop();
    vectors++; if (bus.Valid !== 1'b1 || bus.Bits_out !== e) begin miscompares++; $display("FAIL consume12 got %b/%h want 1/%h", bus.Valid, bus.Bits_out, e); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    logic [17:0] prev, diff;
    int bad;
    do_start(18'd76800);
    repeat (10) tick();
    e = sb_pop();
    vectors++; if (bus.Valid !== 1'b1 || bus.Bits_out !== e) begin miscompares++; $display("FAIL b2b_primed got %b/%h want 1/%h", bus.Valid, bus.Bits_out, e); end
    prev = bus.SRAM_address;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      consume(5'd16);
      e = sb_pop();
      diff = bus.SRAM_address - prev;
      prev = bus.SRAM_address;
      if (bus.Valid !== 1'b1 || bus.Bits_out !== e || diff > 18'd1) begin
        bad++;
        if (bad <= 5) $display("FAIL b2b_step%0d got %b/%h/+%0d want 1/%h/+<=1", i, bus.Valid, bus.Bits_out, diff, e);
      end
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL b2b_total got %0d bad steps want 0", bad); end
`ifdef BITSTREAM_READER_STATS_EN
    vectors++; if (bus.Bits_consumed !== 24'd16000) begin miscompares++; $display("FAIL stats_count got %0d want 16000", bus.Bits_consumed); end
`endif
  endtask

  task automatic test_end_of_memory();
    logic [15:0] e;
    do_start(18'h3FFFE);
    vectors++; if (bus.SRAM_address !== 18'h3FFFE) begin miscompares++; $display("FAIL eom_addr0 got %h want 3fffe", bus.SRAM_address); end
`ifdef BITSTREAM_READER_STATS_EN
    vectors++; if (bus.Bits_consumed !== 24'd0) begin miscompares++; $display("FAIL stats_clear got %0d want 0", bus.Bits_consumed); end
`endif
    tick();
    vectors++; if (bus.SRAM_address !== 18'h3FFFF) begin miscompares++; $display("FAIL eom_addr1 got %h want 3ffff", bus.SRAM_address); end
    tick();
    vectors++; if (bus.End_of_memory !== 1'b1) begin miscompares++; $display("FAIL eom_flag got %b want 1", bus.End_of_memory); end
    tick();
    e = sb_pop();
    vectors++; if (bus.Valid !== 1'b1 || bus.Bits_out !== e) begin miscompares++; $display("FAIL eom_win0 got %b/%h want 1/%h", bus.Valid, bus.Bits_out, e); end
    tick();
    consume(5'd4);
    e = sb_pop();
    vectors++; if (bus.Valid !== 1'b1 || bus.Bits_out !== e) begin miscompares++; $display("FAIL eom_win4 got %b/%h want 1/%h", bus.Valid, bus.Bits_out, e); end
    consume(5'd12);
    e = sb_pop();
    vectors++; if (bus.Valid !== 1'b1 || bus.Bits_out !== e) begin miscompares++; $display("FAIL eom_win16 got %b/%h want 1/%h", bus.Valid, bus.Bits_out, e); end
    consume(5'd16);
    void'(sb_pop());
    vectors++; if (bus.Valid !== 1'b0) begin miscompares++; $display("FAIL eom_drained got %b want 0", bus.Valid); end
    repeat (5) tick();
    vectors++; if (bus.Valid !== 1'b0 || bus.SRAM_address !== 18'h3FFFF || bus.End_of_memory !== 1'b1)
      begin miscompares++; $display("FAIL eom_hold got %b/%h/%b want 0/3ffff/1", bus.Valid, bus.SRAM_address, bus.End_of_memory); end
  endtask

  task automatic test_restart_inflight();
    logic [15:0] e;
    do_start(18'd76800);
    tick();
    do_start(18'h00100);
    vectors++; if (bus.SRAM_address !== 18'h00100) begin miscompares++; $display("FAIL restart_addr got %h want 00100", bus.SRAM_address); end
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) tick();
      vectors++; if (bus.Valid !== (c == 4)) begin miscompares++; $display("FAIL restart_valid_c%0d got %b want %b", c, bus.Valid, c == 4); end
    end
    e = sb_pop();
    vectors++; if (bus.Bits_out !== e) begin miscompares++; $display("FAIL restart_win got %h want %h", bus.Bits_out, e); end
    consume(5'd16);
    e = sb_pop();
    vectors++; if (bus.Valid !== 1'b1 || bus.Bits_out !== e) begin miscompares++; $display("FAIL restart_next got %b/%h want 1/%h", bus.Valid, bus.Bits_out, e); end
  endtask

  task automatic test_error();
    logic [15:0] e;
    int n;
    repeat (3) tick();
    bus.Consume = 1'b1; bus.Consume_count = 5'd17;
    sb_q.push_back(exp_win(base, pos));
    tick();
    bus.Consume = 1'b0;
    e = sb_pop();
    vectors++; if (bus.Error !== 1'b1) begin miscompares++; $display("FAIL err_cnt17 got %b want 1", bus.Error); end
    vectors++; if (bus.Bits_out !== e) begin miscompares++; $display("FAIL err_cnt17_win got %h want %h", bus.Bits_out, e); end
    bus.Consume = 1'b1; bus.Consume_count = 5'd0;
    sb_q.push_back(exp_win(base, pos));
    tick();
    bus.Consume = 1'b0;
    e = sb_pop();
    vectors++; if (bus.Error !== 1'b1 || bus.Bits_out !== e) begin miscompares++; $display("FAIL err_cnt0 got %b/%h want 1/%h", bus.Error, bus.Bits_out, e); end
    do_start(18'h00200);
    vectors++; if (bus.Error !== 1'b0) begin miscompares++; $display("FAIL err_clear got %b want 0", bus.Error); end
    bus.Consume = 1'b1; bus.Consume_count = 5'd4;
    tick();
    bus.Consume = 1'b0;
    vectors++; if (bus.Error !== 1'b1) begin miscompares++; $display("FAIL err_novalid got %b want 1", bus.Error); end
    n = 0;
    while (bus.Valid !== 1'b1 && n < 20) begin tick(); n++; end
    e = sb_pop();
    vectors++; if (bus.Valid !== 1'b1 || bus.Bits_out !== e) begin miscompares++; $display("FAIL err_novalid_win got %b/%h want 1/%h", bus.Valid, bus.Bits_out, e); end
    do_start(18'h00300);
    vectors++; if (bus.Error !== 1'b0) begin miscompares++; $display("FAIL err_clear2 got %b want 0", bus.Error); end
  endtask

  task automatic test_mid_reset();
    repeat (6) tick();
    Resetn = 1'b0;
    #1;
    vectors++; if (bus.Valid !== 1'b0 || bus.SRAM_address !== 18'd0 || bus.Bits_out !== 16'h0)
      begin miscompares++; $display("FAIL mid_reset got %b/%h/%h want 0/0/0", bus.Valid, bus.SRAM_address, bus.Bits_out); end
    tick();
    Resetn = 1'b1;
    tick();
  endtask

  initial begin
    bus.Start = 1'b0;
    bus.Start_address = '0;
    bus.Consume = 1'b0;
    bus.Consume_count = '0;
    test_reset();
    test_start_latency();
    test_partial_consume();
    test_back_to_back();
    test_end_of_memory();
    test_restart_inflight();
    test_error();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
